tt_sweep_ctrl: RTL

Sequencer for the team's 3-input combinational function unit (inputs B, C, D; output Y). On a start request it drives all eight input vectors 000..111 in ascending order. It waits a programmable settle time on each vector, then samples Y into an 8-bit truth-table result. It compares the result against an expected mask and reports pass/fail, the mismatch count and the first failing vector. It sits between a test/configuration master and the function unit, and is the only driver of the unit's inputs.

---
 rtl/tt_sweep_pkg.sv | 18 +
 rtl/tt_settle_timer.sv | 40 ++++
 rtl/tt_sweep_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller.
// Holds the FSM state encoding, the vector count and the widths of the
// vector index and mismatch counter.
package tt_sweep_pkg;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter used to hold each input vector for a settle period.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   load_i     load load_val_i into the counter this cycle
//   load_val_i value to load
//   zero_o     counter is zero (current cycle is a sample cycle)
module tt_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps a 3-input combinational function unit through vectors 000..111,
// samples its output after a programmable settle time into an 8-bit truth
// table, and compares it against an expected mask.
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start, abort    begin a sweep (IDLE only) / cancel the sweep in progress
//   settle          extra wait cycles per vector, latched at start
//   expected        expected truth table, latched at start
//   y               function unit output
//   b, c, d         function unit inputs ({b,c,d} = vector index)
//   busy, done      sweep in progress / one-cycle completion pulse
//   result          captured truth table
//   pass            result matched expected (set with done, held to next start)
//   mismatch_cnt    number of mismatching vectors
//   first_fail      lowest mismatching vector index
//   fail_valid      at least one mismatch seen
//   dbg_state       current FSM state
//
// Handshake: start is a level sampled each cycle; it is accepted only in IDLE
// with abort low and is otherwise dropped, never queued. done is a single
// cycle pulse; result and status outputs stay valid until the next accepted
// start.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [7:0]          expected,
    input  logic                y,
    output logic                b,
    output logic                c,
    output logic                d,
    output logic                busy,
    output logic                done,
    output logic [7:0]          result,
    output logic                pass,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic [2:0]          first_fail,
    output logic                fail_valid,
    output state_e              dbg_state
);

    state_e              state_q,  state_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [7:0]          exp_q,    exp_d;
    logic [7:0]          result_q, result_d;
    logic [CNT_W-1:0]    mm_q,     mm_d;
    logic [IDX_W-1:0]    ff_q,     ff_d;
    logic                fv_q,     fv_d;
    logic                pass_q,   pass_d;
    logic                busy_q,   done_q;

    logic                tmr_load;
    logic [SETTLE_W-1:0] tmr_val;
    logic                tmr_zero;

    tt_settle_timer #(.W(SETTLE_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        result_d = result_q;
        mm_d     = mm_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_val  = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    settle_d = settle;
                    exp_d    = expected;
                    result_d = '0;
                    mm_d     = '0;
                    ff_d     = '0;
                    fv_d     = 1'b0;
                    pass_d   = 1'b0;
                    // The latch register is not yet written, so load from the port.
                    tmr_load = 1'b1;
                    tmr_val  = settle;
                end
            end
            ST_DRIVE: begin
                // Abort takes priority over any sample due this cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (tmr_zero) begin
                    result_d[idx_q] = y;
                    if (y != exp_q[idx_q]) begin
                        mm_d = mm_q + CNT_W'(1);
                        if (!fv_q) begin
                            ff_d = idx_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        // Include the final sample in the verdict.
                        pass_d  = (result_d == exp_q);
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            result_q <= '0;
            mm_q     <= '0;
            ff_q     <= '0;
            fv_q     <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            mm_q     <= mm_d;
            ff_q     <= ff_d;
            fv_q     <= fv_d;
            pass_q   <= pass_d;
            busy_q   <= (state_d == ST_DRIVE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign {b, c, d}    = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;
    assign first_fail   = ff_q;
    assign fail_valid   = fv_q;
    assign dbg_state    = state_q;

endmodule
